alu_exec_unit: RTL

//  Parametrised, handshaked ALU execute unit: decodes ALUOp/funct3/funct7 into an ALU control code and computes the result.

---
 rtl/alu_exec_unit_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshaked operand/result bundle between the register-read stage, the ALU execute unit and writeback.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic            opb5;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      alu_control;
  logic            illegal;

  modport master (
    output in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, alu_control, illegal
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, alu_control, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute unit: decodes ALUOp/funct fields, registers the result behind a valid/ready handshake.
// Define MULDIV_EN to add the M extension (combinational multiply, iterative restoring divide).
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_exec_unit_if.slave bus
);
  localparam logic [4:0] C_ADD    = 5'b00000;
  localparam logic [4:0] C_SUB    = 5'b00001;
  localparam logic [4:0] C_AND    = 5'b00010;
  localparam logic [4:0] C_OR     = 5'b00011;
  localparam logic [4:0] C_SLL    = 5'b00100;
  localparam logic [4:0] C_SLT    = 5'b00101;
  localparam logic [4:0] C_SLTU   = 5'b00110;
  localparam logic [4:0] C_XOR    = 5'b00111;
  localparam logic [4:0] C_SRL    = 5'b01000;
  localparam logic [4:0] C_SRA    = 5'b01001;
`ifdef MULDIV_EN
  localparam logic [4:0] C_MUL    = 5'b10000;
  localparam logic [4:0] C_MULH   = 5'b10001;
  localparam logic [4:0] C_MULHSU = 5'b10010;
  localparam logic [4:0] C_MULHU  = 5'b10011;
  localparam logic [4:0] C_DIV    = 5'b10100;
  localparam logic [4:0] C_DIVU   = 5'b10101;
  localparam logic [4:0] C_REM    = 5'b10110;
  localparam logic [4:0] C_REMU   = 5'b10111;
  localparam int         CW       = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DIVIDE} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;
`endif

  state_t state, nxt, acc_nxt;

  logic [4:0]         ctrl;
  logic               ill_d;
  logic [XLEN-1:0]    res_d;
  logic               start_div;
  logic               in_ready_d;
  logic               accept;

  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic [4:0]         ctrl_q;
  logic               ill_q;

  wire  [XLEN-1:0]    a     = bus.src_a;
  wire  [XLEN-1:0]    b     = bus.src_b;
  wire  [SHAMT_W-1:0] shamt = bus.src_b[SHAMT_W-1:0];

  // decode
  always_comb begin
    ctrl  = C_ADD;
    ill_d = 1'b0;
    case (bus.ALUOp)
      2'b00: ctrl = C_ADD;
      2'b01: ctrl = C_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  ctrl = (bus.funct7b5 & bus.opb5) ? C_SUB : C_ADD;
          3'b001:  ctrl = C_SLL;
          3'b010:  ctrl = C_SLT;
          3'b011:  ctrl = C_SLTU;
          3'b100:  ctrl = C_XOR;
          3'b101:  ctrl = bus.funct7b5 ? C_SRA : C_SRL;
          3'b110:  ctrl = C_OR;
          default: ctrl = C_AND;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
`ifdef MULDIV_EN
    if (bus.ALUOp == 2'b10 && bus.opb5 && bus.funct7b0)
      ctrl = {2'b10, bus.funct3};
`endif
  end

`ifdef MULDIV_EN
  logic [2*XLEN-1:0] a_x, b_x, prod;
  logic              mul_sa, mul_sb;
  logic              div_signed, div_zero, div_ovf, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [XLEN-1:0]   div_rem, div_quo, div_dvs;
  logic [CW-1:0]     div_cnt;
  logic              div_negq, div_negr, div_isrem;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   nrem, nquo, div_fin;
  logic              div_last;

  always_comb begin
    mul_sa = (ctrl == C_MULH) | (ctrl == C_MULHSU);
    mul_sb = (ctrl == C_MULH);
    a_x    = {{XLEN{mul_sa & a[XLEN-1]}}, a};
    b_x    = {{XLEN{mul_sb & b[XLEN-1]}}, b};
    prod   = a_x * b_x;

    is_div     = (ctrl[4:2] == 3'b101);
    div_signed = (ctrl == C_DIV) | (ctrl == C_REM);
    div_zero   = (b == '0);
    div_ovf    = div_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    a_mag      = (div_signed & a[XLEN-1]) ? -a : a;
    b_mag      = (div_signed & b[XLEN-1]) ? -b : b;
  end

  // one restoring step per cycle; the last step also applies the sign fix-up
  always_comb begin
    div_sh   = {div_rem, div_quo[XLEN-1]};
    div_diff = div_sh - {1'b0, div_dvs};
    nrem     = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
    nquo     = {div_quo[XLEN-2:0], ~div_diff[XLEN]};
    div_fin  = div_isrem ? (div_negr ? -nrem : nrem) : (div_negq ? -nquo : nquo);
    div_last = (div_cnt == CW'(XLEN-1));
  end

  assign start_div = is_div & ~div_zero & ~div_ovf;
`else
  logic unused_f7b0;
  assign unused_f7b0 = bus.funct7b0;
  assign start_div   = 1'b0;
`endif

  always_comb begin
    res_d = '0;
    case (ctrl)
      C_ADD:    res_d = a + b;
      C_SUB:    res_d = a - b;
      C_AND:    res_d = a & b;
      C_OR:     res_d = a | b;
      C_XOR:    res_d = a ^ b;
      C_SLL:    res_d = a << shamt;
      C_SRL:    res_d = a >> shamt;
      C_SRA:    res_d = $unsigned($signed(a) >>> shamt);
      C_SLT:    res_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLTU:   res_d = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef MULDIV_EN
      C_MUL:    res_d = prod[XLEN-1:0];
      C_MULH, C_MULHSU, C_MULHU:
                res_d = prod[2*XLEN-1:XLEN];
      // only the single-cycle special cases use these; normal divides go iterative
      C_DIV, C_DIVU: res_d = div_zero ? '1 : a;
      C_REM, C_REMU: res_d = div_zero ? a : '0;
`endif
      default:  res_d = '0;
    endcase
    if (ill_d) res_d = '0;
  end

  // control FSM
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt        = state;
    in_ready_d = reset_n & ((state == S_IDLE) | ((state == S_HOLD) & bus.out_ready));
    accept     = bus.in_valid & in_ready_d;
`ifdef MULDIV_EN
    acc_nxt    = start_div ? S_DIVIDE : S_HOLD;
`else
    acc_nxt    = S_HOLD;
`endif
    case (state)
      S_IDLE: if (accept) nxt = acc_nxt;
      S_HOLD: begin
        if (accept)             nxt = acc_nxt;
        else if (bus.out_ready) nxt = S_IDLE;
      end
`ifdef MULDIV_EN
      S_DIVIDE: if (div_last) nxt = S_HOLD;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ctrl_q   <= '0;
      ill_q    <= 1'b0;
`ifdef MULDIV_EN
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvs   <= '0;
      div_cnt   <= '0;
      div_negq  <= 1'b0;
      div_negr  <= 1'b0;
      div_isrem <= 1'b0;
`endif
    end else begin
      if (accept && !start_div) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
        ctrl_q   <= ctrl;
        ill_q    <= ill_d;
      end
`ifdef MULDIV_EN
      if (accept && start_div) begin
        div_rem   <= '0;
        div_quo   <= a_mag;
        div_dvs   <= b_mag;
        div_cnt   <= '0;
        div_negq  <= div_signed & (a[XLEN-1] ^ b[XLEN-1]);
        div_negr  <= div_signed & a[XLEN-1];
        div_isrem <= ctrl[1];
        ctrl_q    <= ctrl;
        ill_q     <= 1'b0;
      end
      if (state == S_DIVIDE) begin
        div_rem <= nrem;
        div_quo <= nquo;
        div_cnt <= div_cnt + CW'(1);
        if (div_last) begin
          result_q <= div_fin;
          zero_q   <= (div_fin == '0);
        end
      end
`endif
    end
  end

  assign bus.in_ready    = in_ready_d;
  assign bus.out_valid   = (state == S_HOLD);
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.alu_control = ctrl_q;
  assign bus.illegal     = ill_q;
endmodule
